// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        FETCH = 2'b01,
        DRAIN = 2'b10,
        HOLD  = 2'b11
    } state_e;

    typedef enum logic [1:0] {
        FAULT_NONE     = 2'b00,
        FAULT_MISALIGN = 2'b01,
        FAULT_BUS      = 2'b10
    } fault_e;

    localparam logic [31:0] NOP = 32'h0000_0000;

    function automatic logic is_aligned(input logic [31:0] addr);
        return addr[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/fetch_timer.sv
// Request timeout counter: counts unacknowledged request cycles since the last clear.
module fetch_timer
    import fetch_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic count,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // expired marks the TIMEOUT-th request cycle, so the fetch FSM can still honour an ack there
    assign expired = (cnt_q == CW'(TIMEOUT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (count && !expired) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction-fetch stage: samples the PC, reads instruction memory with req/ack,
// and holds the fetched word until decode accepts it.
module instruction_fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc,
    input  logic        flush,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [31:0] pc_plus4,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic        pc_advance,
    output logic [1:0]  fault
);

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] instr_pc_q, instr_pc_d;
    logic [1:0]  fault_q, fault_d;
    logic        timer_clear;
    logic        timer_count;
    logic        timer_expired;

    assign imem_req    = (state_q == FETCH) || (state_q == DRAIN);
    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign fault       = fault_q;
    assign instr_valid = (state_q == HOLD);
    assign pc_advance  = instr_valid & instr_ready & ~flush;
    assign pc_plus4    = instr_pc_q + 32'd4;

    // Fresh timeout window whenever a FETCH or DRAIN phase begins
    assign timer_count = imem_req & ~imem_ack;
    assign timer_clear = (state_d != state_q) && ((state_d == FETCH) || (state_d == DRAIN));

    fetch_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (timer_clear),
        .count   (timer_count),
        .expired (timer_expired)
    );

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        fault_d    = fault_q;
        unique case (state_q)
            IDLE: begin
                pc_d = pc;
                if (!is_aligned(pc)) begin
                    state_d    = HOLD;
                    instr_d    = NOP;
                    instr_pc_d = pc;
                    fault_d    = FAULT_MISALIGN;
                end else begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                // Ack beats both flush-to-drain and the timeout on the same cycle
                if (imem_ack) begin
                    if (flush) begin
                        state_d = IDLE;
                    end else begin
                        state_d    = HOLD;
                        instr_d    = imem_rdata;
                        instr_pc_d = pc_q;
                        fault_d    = FAULT_NONE;
                    end
                end else if (flush) begin
                    state_d = DRAIN;
                end else if (timer_expired) begin
                    state_d    = HOLD;
                    instr_d    = NOP;
                    instr_pc_d = pc_q;
                    fault_d    = FAULT_BUS;
                end
            end
            DRAIN: begin
                if (imem_ack || timer_expired) begin
                    state_d = IDLE;
                end
            end
            HOLD: begin
                if (flush || instr_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pc_q       <= 32'h0000_0000;
            instr_q    <= NOP;
            instr_pc_q <= RESET_PC;
            fault_q    <= FAULT_NONE;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            fault_q    <= fault_d;
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: vector table, flush/reset sequences,
// and randomized fetches against a transaction-level memory/PC model.
module tb_instruction_fetch;

    localparam int          TO  = 16;
    localparam logic [31:0] RPC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] pc = 32'h0;
    logic        flush = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] pc_plus4;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic        pc_advance;
    logic [1:0]  fault;

    always #5 clk = ~clk;

    instruction_fetch #(
        .RESET_PC (RPC),
        .TIMEOUT  (TO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pc          (pc),
        .flush       (flush),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .pc_plus4    (pc_plus4),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .pc_advance  (pc_advance),
        .fault       (fault)
    );

    typedef struct {
        logic [31:0] pc;
        int          waits;
        logic [31:0] rdata;
        int          hold;
        logic [31:0] e_instr;
        logic [1:0]  e_fault;
        logic [31:0] e_pc4;
        int          e_reqs;
        int          e_lat;
    } vec_t;

    int          n_checks = 0;
    int          n_fail = 0;
    int          busy = 0;
    int          left = 0;
    int          last_w = 0;
    int          next_waits = 0;
    int          mem_mode = 0;
    logic [31:0] cfg_rdata = 32'h0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Memory responder: each new request acks after next_waits wait cycles.
    task automatic mem_step();
        if (!imem_req) begin
            busy     = 0;
            imem_ack = 1'b0;
        end else begin
            if (busy == 0) begin
                busy   = 1;
                left   = next_waits;
                last_w = next_waits;
            end
            if (left == 0) begin
                imem_ack = 1'b1;
            end else begin
                imem_ack = 1'b0;
                left--;
            end
        end
        if (imem_ack) imem_rdata = (mem_mode != 0) ? mem_word(imem_addr) : cfg_rdata;
        else          imem_rdata = $urandom;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        mem_step();
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_req"}, 32'(imem_req), 32'd0);
        chk({tag, "_addr"}, imem_addr, 32'd0);
        chk({tag, "_instr"}, instr, 32'd0);
        chk({tag, "_valid"}, 32'(instr_valid), 32'd0);
        chk({tag, "_fault"}, 32'(fault), 32'd0);
        chk({tag, "_instr_pc"}, instr_pc, RPC);
        chk({tag, "_pc_plus4"}, pc_plus4, RPC + 32'd4);
        chk({tag, "_pc_advance"}, 32'(pc_advance), 32'd0);
    endtask

    // Entered and left at a negedge of an IDLE cycle.
    task automatic run_vec(input vec_t v);
        int n;
        int reqs;
        pc         = v.pc;
        next_waits = v.waits;
        cfg_rdata  = v.rdata;
        reqs       = 0;
        for (n = 1; n <= 40; n++) begin
            tick();
            @(negedge clk);
            if (imem_req) begin
                reqs++;
                chk("vec_addr", imem_addr, v.pc);
            end
            if (instr_valid) break;
        end
        chk("vec_latency", 32'(n), 32'(v.e_lat));
        chk("vec_req_cycles", 32'(reqs), 32'(v.e_reqs));
        chk("vec_instr", instr, v.e_instr);
        chk("vec_fault", 32'(fault), 32'(v.e_fault));
        if (v.e_fault != 2'b01) begin
            chk("vec_instr_pc", instr_pc, v.pc);
            chk("vec_pc_plus4", pc_plus4, v.e_pc4);
        end
        for (int h = 0; h < v.hold; h++) begin
            chk("hold_no_adv", 32'(pc_advance), 32'd0);
            tick();
            @(negedge clk);
            chk("hold_valid", 32'(instr_valid), 32'd1);
            chk("hold_instr", instr, v.e_instr);
            chk("hold_fault", 32'(fault), 32'(v.e_fault));
            chk("hold_no_req", 32'(imem_req), 32'd0);
        end
        instr_ready = 1'b1;
        #1;
        chk("accept_adv", 32'(pc_advance), 32'd1);
        tick();
        instr_ready = 1'b0;
        @(negedge clk);
        chk("after_accept_valid", 32'(instr_valid), 32'd0);
        chk("after_accept_adv", 32'(pc_advance), 32'd0);
    endtask

    // Flush during the fetch of pc0 at request cycle fc; redirect to newpc.
    task automatic flush_seq(input logic [31:0] pc0, input int w, input int fc,
                             input logic [31:0] newpc, input int exp_n);
        int n;
        pc         = pc0;
        next_waits = w;
        for (n = 1; n <= 60; n++) begin
            tick();
            flush = (n == fc);
            if (n == fc) next_waits = 0;
            if (n == fc + 1) pc = newpc;
            @(negedge clk);
            if (n == fc) begin
                chk("flush_req", 32'(imem_req), 32'd1);
                chk("flush_addr", imem_addr, pc0);
            end
            if (instr_valid) break;
        end
        flush = 1'b0;
        chk("flush_valid_cycle", 32'(n), 32'(exp_n));
        chk("flush_instr_pc", instr_pc, newpc);
        chk("flush_instr", instr, mem_word(newpc));
        chk("flush_fault", 32'(fault), 32'd0);
        // Flush out of HOLD with ready also high: no advance, instruction dropped
        flush       = 1'b1;
        instr_ready = 1'b1;
        #1;
        chk("hold_flush_adv", 32'(pc_advance), 32'd0);
        tick();
        flush       = 1'b0;
        instr_ready = 1'b0;
        @(negedge clk);
        chk("hold_flush_valid", 32'(instr_valid), 32'd0);
    endtask

    initial begin
        vec_t        vecs[7];
        logic [31:0] cur_pc;
        logic [31:0] e_instr;
        logic [1:0]  e_fault;
        logic        acc;
        logic        pend;
        int          stall;
        int          n_acc;
        bit          drained;

        vecs[0] = '{32'h0000_0000, 0,  32'h0800_0010, 0, 32'h0800_0010, 2'd0, 32'h0000_0004, 1,  2};
        vecs[1] = '{32'h0000_0100, 3,  32'hDEAD_BEEF, 4, 32'hDEAD_BEEF, 2'd0, 32'h0000_0104, 4,  5};
        vecs[2] = '{32'h0000_0006, 0,  32'h1111_1111, 1, 32'h0000_0000, 2'd1, 32'h0000_000A, 0,  1};
        vecs[3] = '{32'hFFFF_FFFC, 1,  32'hCAFE_F00D, 0, 32'hCAFE_F00D, 2'd0, 32'h0000_0000, 2,  3};
        vecs[4] = '{32'h0000_0020, 15, 32'h1357_9BDF, 2, 32'h1357_9BDF, 2'd0, 32'h0000_0024, 16, 17};
        vecs[5] = '{32'h0000_0024, 99, 32'h2468_ACE0, 3, 32'h0000_0000, 2'd2, 32'h0000_0028, 16, 17};
        vecs[6] = '{32'h0000_0033, 0,  32'h7777_7777, 0, 32'h0000_0000, 2'd1, 32'h0000_0037, 0,  1};

        rst_n = 1'b0;
        repeat (2) tick();
        @(negedge clk);
        chk_reset("reset");
        rst_n = 1'b1;

        mem_mode = 0;
        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        mem_mode = 1;
        flush_seq(32'h0000_0008, 10, 2, 32'h0000_0040, 14);
        flush_seq(32'h0000_0010, 1,  2, 32'h0000_0014, 5);

        // Randomized run: PC controller model follows pc_advance; memory picks wait counts.
        cur_pc = 32'h0000_0200;
        pc     = cur_pc;
        acc    = 1'b0;
        pend   = 1'b0;
        stall  = 0;
        n_acc  = 0;
        for (int c = 0; c < 3000; c++) begin
            tick();
            if (acc) begin
                case ($urandom_range(0, 9))
                    0, 1:    cur_pc = $urandom & 32'hFFFF_FFFC;
                    2:       cur_pc = $urandom;
                    default: cur_pc = cur_pc + 32'd4;
                endcase
                pc = cur_pc;
            end
            instr_ready = ($urandom_range(0, 2) != 0);
            next_waits  = ($urandom_range(0, 9) == 0) ? $urandom_range(0, TO + 3)
                                                      : $urandom_range(0, 3);
            @(negedge clk);
            if (imem_req) chk("rnd_addr", imem_addr, cur_pc);
            if (pend) chk("rnd_valid_held", 32'(instr_valid), 32'd1);
            acc = instr_valid & instr_ready;
            chk("rnd_adv", 32'(pc_advance), 32'(acc));
            pend = instr_valid & ~instr_ready;
            if (acc) begin
                if (cur_pc[1:0] != 2'b00) begin
                    e_instr = 32'h0;
                    e_fault = 2'b01;
                end else if (last_w >= TO) begin
                    e_instr = 32'h0;
                    e_fault = 2'b10;
                end else begin
                    e_instr = mem_word(cur_pc);
                    e_fault = 2'b00;
                end
                chk("rnd_instr", instr, e_instr);
                chk("rnd_fault", 32'(fault), 32'(e_fault));
                if (e_fault != 2'b01) begin
                    chk("rnd_instr_pc", instr_pc, cur_pc);
                    chk("rnd_pc_plus4", pc_plus4, cur_pc + 32'd4);
                end
                n_acc++;
                stall = 0;
            end else begin
                stall++;
            end
            if (stall > 100) begin
                chk("rnd_progress", 32'(stall), 32'd0);
                break;
            end
        end
        chk("rnd_some_accepts", 32'(n_acc > 100), 32'd1);

        // Bring the stage back to IDLE before the reset test
        next_waits  = 0;
        instr_ready = 1'b1;
        drained     = 1'b0;
        #1;
        for (int k = 0; k < 60; k++) begin
            if (pc_advance) begin
                drained = 1'b1;
                break;
            end
            tick();
            @(negedge clk);
            #1;
        end
        chk("drain_done", 32'(drained), 32'd1);
        tick();
        instr_ready = 1'b0;
        @(negedge clk);

        pc         = 32'h0000_0050;
        next_waits = 10;
        tick();
        tick();
        @(negedge clk);
        chk("mid_fetch_req", 32'(imem_req), 32'd1);
        chk("mid_fetch_addr", imem_addr, 32'h0000_0050);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset("async_reset");
        @(negedge clk);
        rst_n = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
